// File: rtl/count_bcd_decoder_pkg.sv
// Shared types and constants for the sequential binary-to-BCD decoder.
package count_bcd_pkg;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One BCD digit
    typedef logic [3:0] nibble_t;

    // Double-dabble correction: a digit of 5 or more gets +3 before the shift,
    // so the doubled value carries correctly into the next digit.
    localparam nibble_t ADJ_THRESH = 4'd5;
    localparam nibble_t ADJ_ADD    = 4'd3;

endpackage

// File: rtl/count_bcd_decoder_digit_adj.sv
// Per-digit add-3 correction applied to a scratch nibble before each shift.
// The input never exceeds 9 here, so the corrected value stays within 12
// and a plain 4-bit add cannot wrap.
module bcd_digit_adj
    import count_bcd_pkg::*;
(
    input  nibble_t din,
    output nibble_t dout
);

    assign dout = (din >= ADJ_THRESH) ? nibble_t'(din + ADJ_ADD) : din;

endmodule

// File: rtl/count_bcd_decoder.sv
// Iterative binary-to-BCD decoder for the counter display path.
// One input bit per clock; start is accepted in IDLE or DONE, the result
// appears with a one-cycle done pulse WIDTH edges after acceptance, and
// bcd/overflow hold until the next completion.
module count_bcd_decoder
    import count_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int ITER_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW     = 4 * DIGITS;

    state_t             state;
    logic [SW-1:0]      scratch;
    logic [SW-1:0]      adj;
    logic [SW-1:0]      scratch_nxt;
    logic [WIDTH-1:0]   bin_shift;
    logic [ITER_W-1:0]  iter;
    logic               ovf_sticky;
    logic               ovf_nxt;

    // Corrected copy of every scratch digit
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    // Shift corrected digits left, pulling in the next binary bit; a 1 that
    // leaves the top digit means the value needs more than DIGITS digits.
    assign scratch_nxt = {adj[SW-2:0], bin_shift[WIDTH-1]};
    assign ovf_nxt     = ovf_sticky | adj[SW-1];

    // Sequencer: accept, shift WIDTH times, publish, pulse done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd        <= '0;
            overflow   <= 1'b0;
            scratch    <= '0;
            bin_shift  <= '0;
            iter       <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_shift  <= bin;
                        scratch    <= '0;
                        iter       <= '0;
                        ovf_sticky <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch    <= scratch_nxt;
                    bin_shift  <= bin_shift << 1;
                    ovf_sticky <= ovf_nxt;
                    iter       <= iter + ITER_W'(1);
                    if (iter == ITER_W'(WIDTH - 1)) begin
                        bcd      <= scratch_nxt;
                        overflow <= ovf_nxt;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    // Back-to-back: a start here begins the next conversion
                    if (start) begin
                        bin_shift  <= bin;
                        scratch    <= '0;
                        iter       <= '0;
                        ovf_sticky <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_count_bcd_decoder.sv
// Scoreboard bench for count_bcd_decoder: a 3-digit and a 2-digit instance.
module tb_count_bcd_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [7:0]  bin_a, bin_b;
    logic        busy_a, done_a, overflow_a;
    logic        busy_b, done_b, overflow_b;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [12:0] q_a[$];
    logic [8:0]  q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    count_bcd_decoder #(.WIDTH(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(overflow_a)
    );

    count_bcd_decoder #(.WIDTH(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(overflow_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits by division
    function automatic logic [12:0] ref3(input int v);
        return {(v >= 1000) ? 1'b1 : 1'b0, 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Monitor for the 3-digit instance
    always @(negedge clk) begin : mon_a
        logic [12:0] e;
        if (done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done_a: got bcd %h want no done", bcd_a);
            end else begin
                e = q_a.pop_front();
                check("result_a", {3'b0, overflow_a, bcd_a}, {3'b0, e});
            end
        end
    end

    // Monitor for the 2-digit instance
    always @(negedge clk) begin : mon_b
        logic [8:0] e;
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done_b: got bcd %h want no done", bcd_b);
            end else begin
                e = q_b.pop_front();
                check("result_b", {7'b0, overflow_b, bcd_b}, {7'b0, e});
            end
        end
    end

    // Present start for one accepting edge; returns just after that edge
    task automatic issue(input int d, input logic [7:0] v, input bit push,
                         input logic [12:0] e, input bit hold);
        @(posedge clk); #1;
        if (d == 0) begin
            start_a = 1'b1; bin_a = v;
            if (push) q_a.push_back(e);
        end else begin
            start_b = 1'b1; bin_b = v;
            if (push) q_b.push_back(e[8:0]);
        end
        @(posedge clk); #1;
        if (!hold) begin
            if (d == 0) start_a = 1'b0; else start_b = 1'b0;
        end
    endtask

    // Wait (bounded) for done; optionally check how many busy cycles preceded it
    task automatic wait_done(input int d, input int exp_busy, output int at_cyc);
        int  n;
        bit  seen;
        n = 0; seen = 0; at_cyc = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if ((d == 0) ? done_a : done_b) begin
                seen = 1; at_cyc = cyc;
            end else if ((d == 0) ? busy_a : busy_b) begin
                n++;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL done_timeout: got no done want done within 40 cycles");
        end else begin
            check("busy_at_done", 16'((d == 0) ? busy_a : busy_b), 16'd0);
            if (exp_busy >= 0) check("busy_cycles", 16'(n), 16'(exp_busy));
        end
    endtask

    initial begin
        int t0, t1, v;
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 16'(busy_a), 16'd0);
        check("rst_done", 16'(done_a), 16'd0);
        check("rst_bcd",  16'(bcd_a),  16'd0);
        check("rst_ovf",  16'(overflow_a), 16'd0);
        #10 rst = 1'b0;

        // bin=0: full-length conversion, no early exit
        issue(0, 8'd0, 1, 13'h0000, 0);
        wait_done(0, 8, t0);

        // Directed values
        issue(0, 8'd255, 1, 13'h0255, 0); wait_done(0, 8, t0);
        issue(0, 8'd100, 1, 13'h0100, 0); wait_done(0, 8, t0);
        issue(0, 8'd9,   1, 13'h0009, 0); wait_done(0, 8, t0);

        // Sweep every value in a scrambled order against the division model
        for (int i = 0; i < 256; i++) begin
            v = (i * 37 + 11) % 256;
            issue(0, 8'(v), 1, ref3(v), 0);
            wait_done(0, 8, t0);
        end

        // Start held high; bin changes right after each acceptance
        issue(0, 8'd47, 1, 13'h0047, 1);
        bin_a = 8'd128;
        q_a.push_back(13'h0128);
        wait_done(0, 8, t0);
        @(posedge clk); #1;
        start_a = 1'b0; bin_a = 8'd5;
        wait_done(0, -1, t1);
        check("b2b_spacing", 16'(t1 - t0), 16'd9);

        // start while busy is ignored
        issue(0, 8'd200, 1, 13'h0200, 0);
        repeat (3) @(posedge clk);
        #1 start_a = 1'b1; bin_a = 8'd5;
        @(posedge clk); #1 start_a = 1'b0;
        wait_done(0, -1, t0);
        repeat (12) @(negedge clk);
        check("hold_bcd", 16'(bcd_a), 16'h0200);
        check("hold_ovf", 16'(overflow_a), 16'd0);

        // Reset during the 4th shift cycle aborts immediately
        issue(0, 8'd99, 0, 13'h0000, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 16'(busy_a), 16'd0);
        check("abort_done", 16'(done_a), 16'd0);
        check("abort_bcd",  16'(bcd_a),  16'd0);
        check("abort_ovf",  16'(overflow_a), 16'd0);
        #4 rst = 1'b0;
        issue(0, 8'd37, 1, 13'h0037, 0);
        wait_done(0, 8, t0);

        // Two-digit build: overflow keeps the low digits
        issue(1, 8'd99,  1, {4'b0, 1'b0, 8'h99}, 0); wait_done(1, 8, t0);
        issue(1, 8'd100, 1, {4'b0, 1'b1, 8'h00}, 0); wait_done(1, 8, t0);
        issue(1, 8'd255, 1, {4'b0, 1'b1, 8'h55}, 0); wait_done(1, 8, t0);

        repeat (12) @(negedge clk);
        check("queue_a_drained", 16'(q_a.size()), 16'd0);
        check("queue_b_drained", 16'(q_b.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/count_bcd_decoder.md
Name: count_bcd_decoder

Overview:
Sequential binary-to-BCD decoder for the counter's `count` output. It converts a WIDTH-bit binary value into DIGITS packed BCD nibbles for the 7-segment or hex display path. It uses the iterative shift-add-3 (double-dabble) method, one bit per clock, with a start/busy/done handshake. It sits between the counter and the display driver.

Parameters:
- WIDTH, 8: binary input width; must match the counter's WIDTH.
- DIGITS, 3: number of BCD output digits; the legal range is 1..10.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request conversion of `bin`; sampled only when `busy`=0
- bin  input  WIDTH  binary value to convert; captured on the accepting edge only
- busy  output  1  conversion in progress; `start` is ignored while high
- done  output  1  single-cycle pulse; `bcd` and `overflow` are new this cycle
- bcd  output  4*DIGITS  packed BCD; digit 0 is in bits [3:0]; held between conversions
- overflow  output  1  value did not fit in DIGITS digits; held with `bcd`

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - busy=0, done=0, bcd=0, overflow=0.
  - Internal shift register and iteration counter cleared.
- FSM states are IDLE, SHIFT and DONE.
  - IDLE: busy=0, done=0.
    - If start=1 at an edge: latch bin, clear the scratch digits, set iter=0, go to SHIFT.
  - SHIFT: busy=1. Each edge does the following:
    - Every scratch digit >=5 gets +3 (combinational).
    - Then {digits, bin_shift} shifts left by 1.
    - A 1 shifted out of the top digit sets a sticky overflow bit.
    - iter increments.
    - On the edge where iter reaches WIDTH-1 (the WIDTH-th shift), load `bcd`/`overflow` from the scratch and go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle.
    - If start=1: accept a new conversion and go to SHIFT (back-to-back).
    - Otherwise go to IDLE.
- Latency:
  - Start is sampled at edge E0.
  - `bcd`/`overflow` update and `done` rises at edge E(WIDTH).
  - Back-to-back throughput is one conversion per WIDTH+1 cycles.
- Output holding: `bcd`/`overflow` change only on the completion edge or on reset. Start acceptance does not modify them.
- `bin` may change freely after the accepting edge; the captured copy is used.
- start while busy=1: ignored, with no queueing.
- start held high continuously: each DONE cycle re-accepts, so conversions proceed continuously.
- Reset mid-conversion: aborts immediately, and all outputs go to their reset values.
- Width rule: the scratch register is 4*DIGITS bits. The add-3 check uses a 4-bit compare on each nibble, and the nibble value never exceeds 12 before the shift.
- Overflow semantics:
  - overflow=1 iff bin >= 10**DIGITS.
  - In that case `bcd` holds the low DIGITS digits of the true value. Example: 255 with DIGITS=2 gives 8'h55.
- bin=0: converts in the same WIDTH cycles; there is no early exit.

Decomposition:
- Package count_bcd_pkg holds:
  - the state enum typedef (IDLE/SHIFT/DONE);
  - the nibble typedef;
  - constants ADJ_THRESH=4'd5 and ADJ_ADD=4'd3.
- Iteration counter width is $clog2(WIDTH), computed locally.
- One sub-module, bcd_digit_adj: combinational per-nibble add-3-if->=5. It is instantiated DIGITS times via generate.

Test Plan:
1. WIDTH=8, DIGITS=3. Pulse start with bin=0 → done rises 8 edges later; bcd=12'h000, overflow=0; busy high for exactly 8 cycles.
2. Convert 255, 100 and 9 in turn → bcd = 12'h255, 12'h100, 12'h009, overflow=0. Also run a full random sweep of 0..255 against a reference model.
3. Hold start=1 continuously, changing bin from 47 to 128 one cycle after each acceptance → done pulses every 9 cycles with 12'h047 then 12'h128. This checks capture-on-accept and back-to-back operation.
4. Start bin=200. Pulse start with bin=5 while busy → ignored; result 12'h200; no extra done pulse.
5. Start bin=99 and assert rst at the 4th SHIFT cycle → busy/done/bcd/overflow go to 0 asynchronously. A following start with bin=37 gives 12'h037 after 8 edges.
6. DIGITS=2 build:
   - bin=99 → 8'h99, overflow=0.
   - bin=100 → 8'h00, overflow=1.
   - bin=255 → 8'h55, overflow=1.
